mesh_router: RTL and testbench

- Parametrised 5-port (N,S,E,W,L) mesh router. It is the generic successor to the fixed-shape corner and edge routers.
- Any mesh position is covered by a PORT_EN mask. Flit width, FIFO depth and coordinate width are all parameters.
- Single-flit packets use XY dimension-order routing, per-input FIFOs, per-output round-robin arbitration and credit-based flow control.
- Adds registered outputs, a drop path for unreachable destinations, and an overflow/drop status counter.

---
 rtl/mesh_router.sv | 179 +++++++++++++++++
 tb/tb_mesh_router.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_router.sv
// 5-port mesh router: per-input FIFOs, XY routing, per-output round-robin with credit flow
// control, registered outputs, and a drop path for destinations behind absent ports.
module mesh_router #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XCOORD     = 0,
  parameter int unsigned YCOORD     = 0,
  parameter logic [4:0]  PORT_EN    = 5'b11111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]        in_valid,
  output logic [4:0]        in_credit,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]        out_valid,
  input  logic [4:0]        out_credit,
  output logic [7:0]        drop_cnt,
  output logic              overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0]    Depth = CntW'(FIFO_DEPTH);
  localparam logic [COORD_W-1:0] MyX   = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] MyY   = COORD_W'(YCOORD);

  localparam logic [2:0] PortN = 3'd0;
  localparam logic [2:0] PortS = 3'd1;
  localparam logic [2:0] PortE = 3'd2;
  localparam logic [2:0] PortW = 3'd3;
  localparam logic [2:0] PortL = 3'd4;

  logic [DATA_W-1:0] mem_q [5][FIFO_DEPTH];
  logic [PtrW-1:0]   wr_q [5];
  logic [PtrW-1:0]   rd_q [5];
  logic [CntW-1:0]   cnt_q [5];
  logic [CntW-1:0]   cnt_d [5];
  logic [CntW-1:0]   credit_q [5];
  logic [CntW-1:0]   credit_d [5];
  logic [2:0]        rr_q [5];
  logic [2:0]        rr_d [5];

  logic [5*DATA_W-1:0] out_data_q;
  logic [4:0]          out_valid_q;
  logic [4:0]          in_credit_q;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                overflow_q;

  logic [DATA_W-1:0] head [5];
  logic [2:0]        rte [5];
  logic [2:0]        win [5];
  logic [4:0]        empty, drop, granted, pop, push, gnt;
  logic              ovf_set;
  logic [8:0]        drop_sum;

  function automatic logic [2:0] route_of(input logic [DATA_W-1:0] flit);
    logic [COORD_W-1:0] dx, dy;
    dx = flit[2*COORD_W-1:COORD_W];
    dy = flit[COORD_W-1:0];
    if (dx > MyX) return PortE;
    if (dx < MyX) return PortW;
    if (dy > MyY) return PortN;
    if (dy < MyY) return PortS;
    return PortL;
  endfunction

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      empty[p] = (cnt_q[p] == '0);
      head[p]  = mem_q[p][rd_q[p]];
      rte[p]   = route_of(head[p]);
      // Head bound for an absent output is discarded without arbitration
      drop[p]  = !empty[p] && !PORT_EN[rte[p]];
    end
  end

  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    sum     = '0;
    idx     = '0;
    gnt     = '0;
    granted = '0;
    for (int o = 0; o < 5; o++) begin
      win[o]  = '0;
      rr_d[o] = rr_q[o];
      if (PORT_EN[o] && credit_q[o] != '0) begin
        for (int k = 0; k < 5; k++) begin
          sum = {1'b0, rr_q[o]} + 4'(k);
          idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
          if (!gnt[o] && !empty[idx] && rte[idx] == 3'(o)) begin
            gnt[o]       = 1'b1;
            win[o]       = idx;
            granted[idx] = 1'b1;
          end
        end
      end
      if (gnt[o]) rr_d[o] = (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
    end
  end

  assign pop = drop | granted;

  always_comb begin
    ovf_set = 1'b0;
    for (int p = 0; p < 5; p++) begin
      // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
      push[p] = in_valid[p] && PORT_EN[p] && (cnt_q[p] != Depth || pop[p]);
      if (in_valid[p] && PORT_EN[p] && cnt_q[p] == Depth && !pop[p]) ovf_set = 1'b1;
      unique case ({push[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CntW'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - CntW'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  always_comb begin
    for (int o = 0; o < 5; o++) begin
      credit_d[o] = credit_q[o];
      if (gnt[o] && !out_credit[o]) begin
        credit_d[o] = credit_q[o] - CntW'(1);
      end else if (!gnt[o] && out_credit[o] && credit_q[o] != Depth) begin
        credit_d[o] = credit_q[o] + CntW'(1);
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int p = 0; p < 5; p++) drop_sum = drop_sum + 9'(drop[p]);
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (push[p]) mem_q[p][wr_q[p]] <= in_data[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 5; p++) begin
        wr_q[p]     <= '0;
        rd_q[p]     <= '0;
        cnt_q[p]    <= '0;
        credit_q[p] <= Depth;
        rr_q[p]     <= '0;
      end
      out_data_q  <= '0;
      out_valid_q <= '0;
      in_credit_q <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (push[p]) wr_q[p] <= wr_q[p] + PtrW'(1);
        if (pop[p])  rd_q[p] <= rd_q[p] + PtrW'(1);
        cnt_q[p]    <= cnt_d[p];
        credit_q[p] <= credit_d[p];
        rr_q[p]     <= rr_d[p];
        if (gnt[p]) out_data_q[p*DATA_W +: DATA_W] <= head[win[p]];
      end
      out_valid_q <= gnt;
      in_credit_q <= pop;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_q | ovf_set;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q & PORT_EN;
  assign in_credit = in_credit_q & PORT_EN;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mesh_router.sv
// Bench for mesh_router: a full router at (1,1) and a corner router at (3,3) share stimulus;
// the selected one is compared every cycle against a queue-based model of the routing rules.
module tb_mesh_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] in_data;
  logic [4:0]  in_valid;
  logic [4:0]  out_credit;

  logic [4:0]  a_in_credit, a_out_valid, b_in_credit, b_out_valid;
  logic [79:0] a_out_data, b_out_data;
  logic [7:0]  a_drop, b_drop;
  logic        a_ovf, b_ovf;

  logic        sel;
  logic [4:0]  obs_valid, obs_credit;
  logic [79:0] obs_data;
  logic [7:0]  obs_drop;
  logic        obs_ovf;

  always #5 clk = ~clk;

  mesh_router #(
    .DATA_W(16), .COORD_W(4), .FIFO_DEPTH(4), .XCOORD(1), .YCOORD(1), .PORT_EN(5'b11111)
  ) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_credit(a_in_credit),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_credit(out_credit),
    .drop_cnt(a_drop), .overflow(a_ovf)
  );

  mesh_router #(
    .DATA_W(16), .COORD_W(4), .FIFO_DEPTH(4), .XCOORD(3), .YCOORD(3), .PORT_EN(5'b11010)
  ) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_credit(b_in_credit),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_credit(out_credit),
    .drop_cnt(b_drop), .overflow(b_ovf)
  );

  assign obs_valid  = sel ? b_out_valid : a_out_valid;
  assign obs_credit = sel ? b_in_credit : a_in_credit;
  assign obs_data   = sel ? b_out_data  : a_out_data;
  assign obs_drop   = sel ? b_drop      : a_drop;
  assign obs_ovf    = sel ? b_ovf       : a_ovf;

  // Reference model state
  int          mx, my;
  logic [4:0]  men;
  logic [15:0] mq [5][$];
  int          cred [5];
  int          rr [5];
  int          dcnt;
  logic        movf;
  logic [4:0]  e_valid, e_credit;
  logic [79:0] e_data;

  int vectors = 0;
  int miscompares = 0;
  int sent, n;
  logic saw5;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int route(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[7:4]);
    dy = int'(f[3:0]);
    if (dx > mx) return 2;
    if (dx < mx) return 3;
    if (dy > my) return 0;
    if (dy < my) return 1;
    return 4;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 5; p++) begin
      mq[p].delete();
      cred[p] = 4;
      rr[p]   = 0;
    end
    dcnt = 0; movf = 1'b0; e_valid = '0; e_credit = '0; e_data = '0;
  endtask

  // One clock edge worth of router behaviour, using the inputs presented this cycle
  task automatic model_step();
    int rt [5];
    bit has [5];
    logic [4:0] popm, nv;
    int nd, q;
    nd = 0; popm = '0; nv = '0;
    for (int p = 0; p < 5; p++) begin
      has[p] = mq[p].size() > 0;
      rt[p]  = 0;
      if (has[p]) rt[p] = route(mq[p][0]);
    end
    for (int p = 0; p < 5; p++) begin
      if (has[p] && !men[rt[p]]) begin
        popm[p] = 1'b1;
        nd++;
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (men[o] && cred[o] > 0) begin
        for (int k = 0; k < 5; k++) begin
          q = (rr[o] + k) % 5;
          if (!nv[o] && has[q] && !popm[q] && rt[q] == o) begin
            nv[o] = 1'b1;
            e_data[o*16 +: 16] = mq[q][0];
            popm[q] = 1'b1;
            rr[o] = (q + 1) % 5;
          end
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (nv[o] && !out_credit[o]) cred[o]--;
      else if (!nv[o] && out_credit[o] && cred[o] < 4) cred[o]++;
    end
    for (int p = 0; p < 5; p++) if (popm[p]) void'(mq[p].pop_front());
    for (int p = 0; p < 5; p++) begin
      if (in_valid[p] && men[p]) begin
        if (mq[p].size() < 4) mq[p].push_back(in_data[p*16 +: 16]);
        else movf = 1'b1;
      end
    end
    dcnt = (dcnt + nd > 255) ? 255 : dcnt + nd;
    e_valid = nv;
    e_credit = popm;
  endtask

  task automatic compare_all();
    check("out_valid", 80'(obs_valid), 80'(e_valid));
    check("out_data", obs_data, e_data);
    check("in_credit", 80'(obs_credit), 80'(e_credit));
    check("drop_cnt", 80'(obs_drop), 80'(dcnt));
    check("overflow", 80'(obs_ovf), 80'(movf));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Called just after a rising edge; leaves reset released before the next edge
  task automatic do_reset(input logic s);
    sel = s; in_valid = '0; out_credit = '0; in_data = '0;
    if (s) begin mx = 3; my = 3; men = 5'b11010; end
    else   begin mx = 1; my = 1; men = 5'b11111; end
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    #3 rst = 1'b1;
  endtask

  task automatic burst_l_to_e(input int cnt, output int got);
    got = 0;
    for (int i = 0; i < cnt; i++) begin
      in_data = '0;
      in_data[64 +: 16] = 16'h0021 | 16'((i + 1) << 8);
      in_valid = 5'b10000;
      cycle();
      if (obs_valid[2]) got++;
    end
    in_valid = '0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_valid[2]) got++;
    end
  endtask

  task automatic random_run(input int cycles, input int maxc);
    for (int i = 0; i < cycles; i++) begin
      for (int p = 0; p < 5; p++) begin
        in_valid[p]   = ($urandom_range(0, 9) < 4);
        out_credit[p] = ($urandom_range(0, 1) == 1);
        in_data[p*16 +: 16] = {8'($urandom), 4'($urandom_range(0, maxc)),
                               4'($urandom_range(0, maxc))};
      end
      cycle();
    end
    in_valid = '0;
    for (int i = 0; i < 20; i++) begin
      out_credit = 5'($urandom);
      cycle();
    end
    out_credit = '0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; in_valid = '0; out_credit = '0; in_data = '0;
    mx = 1; my = 1; men = 5'b11111;
    model_reset();
    @(posedge clk);
    #1;

    // L -> E single flit, two-cycle latency
    do_reset(1'b0);
    in_data[64 +: 16] = 16'h0021; in_valid = 5'b10000;
    cycle();
    in_valid = '0;
    cycle();
    check("t1_valid", 80'(obs_valid), 80'(5'b00100));
    check("t1_data", 80'(obs_data[32 +: 16]), 80'(16'h0021));
    check("t1_credit", 80'(obs_credit), 80'(5'b10000));

    // N, S, W all to L; round robin from rr=0
    do_reset(1'b0);
    in_data[0 +: 16] = 16'hA011; in_data[16 +: 16] = 16'hB011; in_data[48 +: 16] = 16'hC011;
    in_valid = 5'b01011;
    cycle();
    in_valid = '0;
    cycle();
    check("t2_first", 80'({obs_valid[4], obs_data[64 +: 16]}), 80'({1'b1, 16'hA011}));
    cycle();
    check("t2_second", 80'({obs_valid[4], obs_data[64 +: 16]}), 80'({1'b1, 16'hB011}));
    cycle();
    check("t2_third", 80'({obs_valid[4], obs_data[64 +: 16]}), 80'({1'b1, 16'hC011}));

    // Credit stall: only four of five go until a credit returns
    do_reset(1'b0);
    burst_l_to_e(5, sent);
    check("t3_sent", 80'(sent), 80'(4));
    out_credit = 5'b00100;
    cycle();
    out_credit = '0;
    check("t3_wait", 80'(obs_valid[2]), 80'(1'b0));
    cycle();
    check("t3_fifth", 80'({obs_valid[2], obs_data[32 +: 16]}), 80'({1'b1, 16'h0521}));

    // Corner router: destination behind absent E is dropped
    do_reset(1'b1);
    in_data[64 +: 16] = 16'h0043; in_valid = 5'b10000;
    cycle();
    in_valid = '0;
    cycle();
    check("t4_drop", 80'(obs_drop), 80'(8'd1));
    check("t4_credit", 80'(obs_credit), 80'(5'b10000));
    check("t4_noout", 80'(obs_valid), 80'(5'b00000));

    // Overflow on S while E has no credit
    do_reset(1'b0);
    burst_l_to_e(4, sent);
    for (int i = 0; i < 5; i++) begin
      in_data = '0;
      in_data[16 +: 16] = 16'h0021 | 16'((i + 1) << 12);
      in_valid = 5'b00010;
      cycle();
    end
    in_valid = '0;
    cycle();
    check("t5_overflow", 80'(obs_ovf), 80'(1'b1));
    n = 0; saw5 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      out_credit = (j % 2 == 0) ? 5'b00100 : 5'b00000;
      cycle();
      if (obs_valid[2]) begin
        n++;
        if (obs_data[44 +: 4] == 4'd5) saw5 = 1'b1;
      end
    end
    out_credit = '0;
    check("t5_retained", 80'(n), 80'(4));
    check("t5_fifth_lost", 80'(saw5), 80'(1'b0));

    // Asynchronous reset while a flit is on the output
    do_reset(1'b0);
    in_data[64 +: 16] = 16'h0021; in_valid = 5'b10000;
    cycle();
    in_valid = '0;
    cycle();
    check("t6_pre", 80'(obs_valid), 80'(5'b00100));
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", 80'(obs_valid), 80'(5'b00000));
    check("t6_async_data", obs_data, 80'(0));
    model_reset();
    compare_all();
    #2 rst = 1'b1;
    burst_l_to_e(5, sent);
    check("t6_credits", 80'(sent), 80'(4));

    // Drop counter saturation on the corner router
    do_reset(1'b1);
    for (int i = 0; i < 100; i++) begin
      for (int p = 0; p < 5; p++) in_data[p*16 +: 16] = 16'h0043;
      in_valid = 5'b11111;
      cycle();
    end
    in_valid = '0;
    cycle();
    cycle();
    check("t7_drop_sat", 80'(obs_drop), 80'(8'hFF));

    // Randomised traffic on both shapes
    do_reset(1'b0);
    random_run(400, 2);
    do_reset(1'b1);
    random_run(400, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
